dht_sensor_reader: RTL
======================

Name: dht_sensor_reader

Overview:
- Parametrised single-wire reader for DHT11/DHT22-class humidity/temperature sensors, clocked at 1 MHz so one cycle is 1 µs.
- Drives the host start pulse, decodes the 40-bit frame by pulse width, and optionally verifies the checksum.
- Retries automatically with an inter-read cooldown, and presents the result with a start/busy/done handshake to the sensor-polling controller above it.

Parameters:
- CNT_W, 20, width of the shared µs counter (must hold the largest timing parameter).
- START_LOW_US, 19000, host low pulse length.
- START_HIGH_US, 20, host release/high time before handing the line over.
- BIT_THRESH_US, 50, bit decodes as 1 when high time > threshold, else 0.
- TIMEOUT_US, 1000, maximum wait for any expected sensor edge.
- MAX_RETRIES, 2, extra attempts after a failed read (0 = no retry).
- COOLDOWN_US, 1000000, idle time between attempts.

Ports:
- clock_1M  input  1  1 MHz clock
- reset  input  1  asynchronous, active-low
- start  input  1  request a read; sampled only in IDLE
- dht_io  inout  1  sensor data line; open-drain style, driven 0 or z only
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse when the final outcome is ready
- data_out  output  40  last good frame {RH_int, RH_dec, T_int, T_dec, checksum}
- error  output  1  final outcome of last request failed
- error_code  output  2  0 none, 1 no response, 2 bit timeout, 3 checksum

Behaviour:
- Reset: line released (z), state IDLE, busy=0, done=0, data_out=0, error=0, error_code=0, retry count 0. Reset mid-transfer releases the line at once.
- dht_io is sampled through a 2-flop synchronizer; all decisions use the synced value.
- IDLE: start=1 → START_LOW, drive 0, clear counter, clear error/error_code, busy=1. start while busy is ignored.
- START_LOW: counter reaches START_LOW_US-1 → release line, go to START_HIGH.
- START_HIGH: after START_HIGH_US cycles → RESP_WAIT_LOW.
- RESP_WAIT_LOW → RESP_WAIT_HIGH → RESP_WAIT_END: these follow the sensor ack low, then high, then the falling edge into the first bit. Each state clears the counter on entry. Counter > TIMEOUT_US → FAIL with code 1.
- BIT_LOW: wait for high, then clear the counter and go to BIT_HIGH.
- BIT_HIGH: count high cycles. On the falling edge, shift in (count > BIT_THRESH_US) MSB-first. After 40 bits → CHECK, otherwise → BIT_LOW. Timeout in BIT_LOW/BIT_HIGH → FAIL with code 2.
- CHECK: on success, data_out is loaded, done pulses and busy falls in the same cycle; state → IDLE.
- FAIL: if retry count < MAX_RETRIES, increment it and go to COOLDOWN, then START_LOW. Otherwise set error=1 and error_code, pulse done, busy=0, reset retry count, → IDLE. data_out is unchanged on any failure.
- COOLDOWN: line released for COOLDOWN_US cycles; busy stays 1.
- The counter saturates and never wraps.
- error/error_code hold until the next accepted start.

Optional Feature:
- DHT_CHECKSUM_EN defined: CHECK compares byte4 with (byte0+byte1+byte2+byte3) mod 256. Mismatch → FAIL with code 3 (retries apply).
- Undefined: CHECK always succeeds and code 3 is never produced.

Decomposition:
- dht_pkg holds the state encoding localparams, the error code constants (ERR_NONE/ERR_NORESP/ERR_BITTO/ERR_CSUM) and the frame width of 40.
- One sub-module, dht_line_sync: the 2-flop synchronizer plus rise/fall edge pulses.
- FSM, counter and shift register stay in the top level.

Test Plan:
- Sensor model gives 80 µs low / 80 µs high ack, bits 50 µs low + 28 µs (0) or 70 µs (1) high, frame 0x350018004D → one done pulse, data_out=0x350018004D, error=0, busy low same cycle.
- Line held high after start, MAX_RETRIES=2, COOLDOWN_US=100 → exactly 3 start-low pulses of 19000 µs, then done with error=1, error_code=1, data_out keeps prior value.
- Frame 0x350018004E: with DHT_CHECKSUM_EN → error_code=3 after 3 attempts; without it → data_out=0x350018004E, error=0.
- Sensor holds high during bit 17 for >1000 µs → error_code=2 (retries exhausted), line released (z).
- Assert reset mid-START_LOW at 5000 µs → dht_io goes z immediately, busy=0 and data_out=0. Later start → normal read.
- start pulsed during a read → ignored (single done). High time 51 µs → bit 1, 49 µs → bit 0 (allowing for the synchronizer delay, which shifts both edges equally).

Source files
------------

// File: rtl/dht_pkg.sv
// Shared definitions for the DHT11/DHT22 single-wire reader.
// Holds the FSM state encoding, error codes and frame geometry.
// The checksum helper is used only when DHT_CHECKSUM_EN is defined.
package dht_pkg;

  localparam int FRAME_W = 40;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_NORESP = 2'd1;
  localparam logic [1:0] ERR_BITTO  = 2'd2;
  localparam logic [1:0] ERR_CSUM   = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START_LOW,
    ST_START_HIGH,
    ST_RESP_WAIT_LOW,
    ST_RESP_WAIT_HIGH,
    ST_RESP_WAIT_END,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_CHECK,
    ST_FAIL,
    ST_COOLDOWN
  } state_t;

  // Byte 4 must equal the 8-bit sum of bytes 0..3.
  function automatic logic csum_ok(input logic [FRAME_W-1:0] f);
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return s == f[7:0];
  endfunction

endpackage

// File: rtl/dht_line_sync.sv
// Two-flop synchronizer for the sensor line plus rise/fall edge pulses.
// Latency: synced level 2 cycles after the pin; edge pulses in the same cycle as the synced change.
// Idle (reset) value is high, matching a pulled-up released line.
module dht_line_sync (
  input  logic clock_1M,
  input  logic reset,
  input  logic i_line,
  output logic o_line,
  output logic o_rise,
  output logic o_fall
);

  // r_sync[1] is the synchronized level, r_sync[2] its previous value for edge detection.
  logic [2:0] r_sync;

  // Shift the raw pin through the synchronizer chain.
  always_ff @(posedge clock_1M or negedge reset) begin
    if (!reset) r_sync <= 3'b111;
    else        r_sync <= {r_sync[1:0], i_line};
  end

  assign o_line = r_sync[1];
  assign o_rise =  r_sync[1] & ~r_sync[2];
  assign o_fall = ~r_sync[1] &  r_sync[2];

endmodule

// File: rtl/dht_sensor_reader.sv
// DHT11/DHT22 reader: start pulse, 40-bit pulse-width decode, retry with cooldown, start/busy/done handshake.
// Latency: one full sensor transaction (ms range); done is a one-cycle pulse with busy dropping in that cycle.
// start is sampled only in IDLE; optional checksum verification enabled by the DHT_CHECKSUM_EN macro.
module dht_sensor_reader
  import dht_pkg::*;
#(
  parameter int CNT_W         = 20,
  parameter int START_LOW_US  = 19000,
  parameter int START_HIGH_US = 20,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US    = 1000,
  parameter int MAX_RETRIES   = 2,
  parameter int COOLDOWN_US   = 1000000
) (
  input  logic                clock_1M,
  input  logic                reset,
  input  logic                start,
  inout  wire                 dht_io,
  output logic                busy,
  output logic                done,
  output logic [FRAME_W-1:0]  data_out,
  output logic                error,
  output logic [1:0]          error_code
);

  localparam int RETRY_W = $clog2(MAX_RETRIES + 2);

  localparam logic [CNT_W-1:0]   L_LOW_END  = CNT_W'(START_LOW_US - 1);
  localparam logic [CNT_W-1:0]   L_HIGH_END = CNT_W'(START_HIGH_US - 1);
  localparam logic [CNT_W-1:0]   L_COOL_END = CNT_W'(COOLDOWN_US - 1);
  localparam logic [CNT_W-1:0]   L_TIMEOUT  = CNT_W'(TIMEOUT_US);
  localparam logic [CNT_W-1:0]   L_THRESH   = CNT_W'(BIT_THRESH_US);
  localparam logic [RETRY_W-1:0] L_RETRIES  = RETRY_W'(MAX_RETRIES);
  localparam logic [5:0]         L_LAST_BIT = 6'(FRAME_W - 1);

  state_t               r_state, w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [FRAME_W-1:0]   r_shift;
  logic [5:0]           r_bit_cnt;
  logic [RETRY_W-1:0]   r_retry;
  logic [1:0]           r_fail_code;
  logic                 r_drive_low;
  logic                 r_busy, r_done, r_error;
  logic [1:0]           r_error_code;
  logic [FRAME_W-1:0]   r_data;

  logic                 w_line, w_rise, w_fall;
  logic                 w_accept, w_shift, w_succeed, w_fail_now, w_retry, w_give_up;
  logic [1:0]           w_fail_code;
  logic                 w_bit;

  dht_line_sync u_sync (
    .clock_1M (clock_1M),
    .reset    (reset),
    .i_line   (dht_io),
    .o_line   (w_line),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  // Open-drain: only ever pull low or release.
  assign dht_io = r_drive_low ? 1'b0 : 1'bz;

  assign busy       = r_busy;
  assign done       = r_done;
  assign data_out   = r_data;
  assign error      = r_error;
  assign error_code = r_error_code;

  // Counter holds cycles-1 of the high phase, so "high time > threshold" is cnt >= threshold.
  assign w_bit = (r_cnt >= L_THRESH);

  // Next-state and transition strobes.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_succeed   = 1'b0;
    w_fail_now  = 1'b0;
    w_fail_code = ERR_NONE;
    w_retry     = 1'b0;
    w_give_up   = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_accept = 1'b1;
        w_next   = ST_START_LOW;
      end
      ST_START_LOW:  if (r_cnt >= L_LOW_END)  w_next = ST_START_HIGH;
      ST_START_HIGH: if (r_cnt >= L_HIGH_END) w_next = ST_RESP_WAIT_LOW;
      ST_RESP_WAIT_LOW, ST_RESP_WAIT_HIGH, ST_RESP_WAIT_END: begin
        if (r_state == ST_RESP_WAIT_LOW && !w_line)       w_next = ST_RESP_WAIT_HIGH;
        else if (r_state == ST_RESP_WAIT_HIGH && w_line)  w_next = ST_RESP_WAIT_END;
        else if (r_state == ST_RESP_WAIT_END && !w_line)  w_next = ST_BIT_LOW;
        else if (r_cnt > L_TIMEOUT) begin
          w_fail_now  = 1'b1;
          w_fail_code = ERR_NORESP;
          w_next      = ST_FAIL;
        end
      end
      ST_BIT_LOW: begin
        if (w_rise) w_next = ST_BIT_HIGH;
        else if (r_cnt > L_TIMEOUT) begin
          w_fail_now  = 1'b1;
          w_fail_code = ERR_BITTO;
          w_next      = ST_FAIL;
        end
      end
      ST_BIT_HIGH: begin
        if (w_fall) begin
          w_shift = 1'b1;
          w_next  = (r_bit_cnt == L_LAST_BIT) ? ST_CHECK : ST_BIT_LOW;
        end else if (r_cnt > L_TIMEOUT) begin
          w_fail_now  = 1'b1;
          w_fail_code = ERR_BITTO;
          w_next      = ST_FAIL;
        end
      end
      ST_CHECK: begin
`ifdef DHT_CHECKSUM_EN
        if (csum_ok(r_shift)) begin
          w_succeed = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_fail_now  = 1'b1;
          w_fail_code = ERR_CSUM;
          w_next      = ST_FAIL;
        end
`else
        w_succeed = 1'b1;
        w_next    = ST_IDLE;
`endif
      end
      ST_FAIL: begin
        if (r_retry < L_RETRIES) begin
          w_retry = 1'b1;
          w_next  = ST_COOLDOWN;
        end else begin
          w_give_up = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_COOLDOWN: if (r_cnt >= L_COOL_END) w_next = ST_START_LOW;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock_1M or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Shared µs counter: cleared on every state change, saturates instead of wrapping.
  always_ff @(posedge clock_1M or negedge reset) begin
    if (!reset)                       r_cnt <= '0;
    else if (w_next != r_state)       r_cnt <= '0;
    else if (r_cnt != {CNT_W{1'b1}})  r_cnt <= r_cnt + 1'b1;
  end

  // Line driver, shift register, bit count and retry bookkeeping.
  always_ff @(posedge clock_1M or negedge reset) begin
    if (!reset) begin
      r_drive_low <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_retry     <= '0;
      r_fail_code <= ERR_NONE;
    end else begin
      r_drive_low <= (w_next == ST_START_LOW);
      if (w_next == ST_START_LOW) r_bit_cnt <= '0;
      else if (w_shift) begin
        r_shift   <= {r_shift[FRAME_W-2:0], w_bit};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_succeed || w_give_up) r_retry <= '0;
      else if (w_retry)           r_retry <= r_retry + 1'b1;
      if (w_fail_now) r_fail_code <= w_fail_code;
    end
  end

  // Host-facing handshake and result registers.
  always_ff @(posedge clock_1M or negedge reset) begin
    if (!reset) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_error_code <= ERR_NONE;
      r_data       <= '0;
    end else begin
      r_done <= w_succeed | w_give_up;
      if (w_accept)                    r_busy <= 1'b1;
      else if (w_succeed || w_give_up) r_busy <= 1'b0;
      if (w_accept) begin
        r_error      <= 1'b0;
        r_error_code <= ERR_NONE;
      end else if (w_give_up) begin
        r_error      <= 1'b1;
        r_error_code <= r_fail_code;
      end
      if (w_succeed) r_data <= r_shift;
    end
  end

endmodule
